// File: rtl/mem_req_pkg.sv
// Shared types, widths and tag packing for the single-word memory requester.
package mem_req_pkg;

    localparam int unsigned MEM_TAG_W    = 7;
    localparam int unsigned CLIENT_TAG_W = 5;
    localparam int unsigned WORD_W       = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } req_state_e;

    // The low two tag bits carry the word index so each ack names its word.
    function automatic logic [MEM_TAG_W-1:0] pack_tag(input logic [CLIENT_TAG_W-1:0] tag,
                                                      input logic [1:0]              idx);
        return {tag, idx};
    endfunction

endpackage

// File: rtl/mem_req_timeout.sv
// Per-word ack timer: cleared on issue, counts while waiting, saturates at TIMEOUT-1.
module mem_req_timeout #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CntW-1:0] cnt_q;

    assign expired_o = (cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mem_requester.sv
// Splits one multi-word client request into single-word memory transactions and
// gathers the read data into a single tagged response.
module mem_requester
    import mem_req_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 4,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_wr,
    input  logic                        req_gm_or_lds,
    input  logic [WORD_W-1:0]           req_addr,
    input  logic [2:0]                  req_count,
    input  logic [WORD_W*MAX_WORDS-1:0] req_wr_data,
    input  logic [CLIENT_TAG_W-1:0]     req_tag,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [WORD_W*MAX_WORDS-1:0] resp_rd_data,
    output logic [CLIENT_TAG_W-1:0]     resp_tag,
    output logic                        resp_err,
    output logic                        mem_rd_en,
    output logic                        mem_wr_en,
    output logic                        mem_gm_or_lds,
    output logic [WORD_W-1:0]           mem_addresses,
    output logic [WORD_W-1:0]           mem_wr_data,
    output logic [MEM_TAG_W-1:0]        mem_input_tag,
    input  logic [WORD_W-1:0]           mem_rd_data,
    input  logic                        mem_ack,
    input  logic [MEM_TAG_W-1:0]        mem_output_tag
);

    localparam logic [2:0] MaxCount = 3'(MAX_WORDS);

    req_state_e                  state_q;
    logic                        wr_q;
    logic [WORD_W-1:0]           base_q;
    logic [2:0]                  count_q;
    logic [1:0]                  idx_q;
    logic [CLIENT_TAG_W-1:0]     tag_q;
    logic [WORD_W*MAX_WORDS-1:0] wr_data_q;
    logic [WORD_W*MAX_WORDS-1:0] rd_words_q;
    logic                        err_q;

    logic       expired;
    logic       tag_match;
    logic       advance;
    logic       last_word;
    logic [1:0] idx_next;

    assign tag_match = mem_ack && (mem_output_tag == mem_input_tag);
    assign advance   = (state_q == StWait) && (tag_match || expired);
    assign last_word = (({1'b0, idx_q} + 3'd1) >= count_q);
    assign idx_next  = idx_q + 2'd1;

    assign resp_rd_data = rd_words_q;
    assign resp_tag     = tag_q;
    assign resp_err     = err_q;

    mem_req_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_q == StIssue),
        .en_i     (state_q == StWait),
        .expired_o(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            wr_q          <= 1'b0;
            base_q        <= '0;
            count_q       <= '0;
            idx_q         <= '0;
            tag_q         <= '0;
            wr_data_q     <= '0;
            rd_words_q    <= '0;
            err_q         <= 1'b0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            mem_rd_en     <= 1'b0;
            mem_wr_en     <= 1'b0;
            mem_gm_or_lds <= 1'b0;
            mem_addresses <= '0;
            mem_wr_data   <= '0;
            mem_input_tag <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        wr_q       <= req_wr;
                        base_q     <= req_addr;
                        tag_q      <= req_tag;
                        wr_data_q  <= req_wr_data;
                        rd_words_q <= '0;
                        idx_q      <= 2'd0;
                        if (req_count == 3'd0) begin
                            count_q <= 3'd1;
                            err_q   <= 1'b0;
                        end else if (req_count > MaxCount) begin
                            count_q <= MaxCount;
                            err_q   <= 1'b1;
                        end else begin
                            count_q <= req_count;
                            err_q   <= 1'b0;
                        end
                        req_ready     <= 1'b0;
                        mem_rd_en     <= !req_wr;
                        mem_wr_en     <= req_wr;
                        mem_gm_or_lds <= req_gm_or_lds;
                        mem_addresses <= req_addr;
                        mem_wr_data   <= req_wr_data[WORD_W-1:0];
                        mem_input_tag <= pack_tag(req_tag, 2'd0);
                        state_q       <= StIssue;
                    end
                end
                StIssue: begin
                    mem_rd_en <= 1'b0;
                    mem_wr_en <= 1'b0;
                    state_q   <= StWait;
                end
                StWait: begin
                    if (mem_ack && !tag_match) begin
                        err_q <= 1'b1;
                    end
                    // Address is still held, so the combinational read data belongs to this word.
                    if (tag_match && !wr_q) begin
                        rd_words_q[WORD_W*idx_q +: WORD_W] <= mem_rd_data;
                    end
                    if (advance) begin
                        if (!tag_match) begin
                            err_q <= 1'b1;
                        end
                        if (last_word) begin
                            resp_valid <= 1'b1;
                            state_q    <= StResp;
                        end else begin
                            idx_q         <= idx_next;
                            mem_rd_en     <= !wr_q;
                            mem_wr_en     <= wr_q;
                            mem_addresses <= base_q + {28'd0, idx_next, 2'b00};
                            mem_wr_data   <= wr_data_q[WORD_W*idx_next +: WORD_W];
                            mem_input_tag <= pack_tag(tag_q, idx_next);
                            state_q       <= StIssue;
                        end
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_requester.sv
// Randomized bench for mem_requester with a reactive memory model and a
// transaction-level reference of expected accesses, responses and latency.
module tb_mem_requester;
    import mem_req_pkg::*;

    localparam int MAX_WORDS = 4;
    localparam int TIMEOUT   = 16;
    localparam int DW        = 32 * MAX_WORDS;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic          req_gm_or_lds;
    logic [31:0]   req_addr;
    logic [2:0]    req_count;
    logic [DW-1:0] req_wr_data;
    logic [4:0]    req_tag;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rd_data;
    logic [4:0]    resp_tag;
    logic          resp_err;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic          mem_gm_or_lds;
    logic [31:0]   mem_addresses;
    logic [31:0]   mem_wr_data;
    logic [6:0]    mem_input_tag;
    logic [31:0]   mem_rd_data;
    logic          mem_ack;
    logic [6:0]    mem_output_tag;

    mem_requester #(
        .MAX_WORDS(MAX_WORDS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wr        (req_wr),
        .req_gm_or_lds (req_gm_or_lds),
        .req_addr      (req_addr),
        .req_count     (req_count),
        .req_wr_data   (req_wr_data),
        .req_tag       (req_tag),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rd_data  (resp_rd_data),
        .resp_tag      (resp_tag),
        .resp_err      (resp_err),
        .mem_rd_en     (mem_rd_en),
        .mem_wr_en     (mem_wr_en),
        .mem_gm_or_lds (mem_gm_or_lds),
        .mem_addresses (mem_addresses),
        .mem_wr_data   (mem_wr_data),
        .mem_input_tag (mem_input_tag),
        .mem_rd_data   (mem_rd_data),
        .mem_ack       (mem_ack),
        .mem_output_tag(mem_output_tag)
    );

    typedef struct packed {
        logic        wr;
        logic        lds;
        logic [31:0] addr;
        logic [6:0]  tag;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        int         due;
        logic [6:0] tag;
        bit         chk;
    } ack_t;

    logic [31:0] gm_mem     [256];
    logic [31:0] lds_mem    [256];
    logic [31:0] shadow_gm  [256];
    logic [31:0] shadow_lds [256];

    txn_t        exp_q[$];
    ack_t        ack_q[$];
    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          drop_idx = -1;
    int          bad_idx  = -1;
    logic [31:0] last_addr = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd_data = mem_gm_or_lds ? lds_mem[mem_addresses[9:2]] : gm_mem[mem_addresses[9:2]];

    task automatic check_eq(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Memory responder and access monitor: acks one cycle after the strobe unless told
    // to drop the ack or to precede it with a wrong-tag ack.
    always @(negedge clk) begin
        txn_t t;
        ack_t a;
        int   idx;
        cyc++;
        mem_ack = 1'b0;
        if (ack_q.size() > 0 && ack_q[0].due <= cyc) begin
            a = ack_q.pop_front();
            mem_ack        = 1'b1;
            mem_output_tag = a.tag;
            if (a.chk) check_eq("addr_hold", mem_addresses, last_addr);
        end
        if (rst_n && (mem_rd_en || mem_wr_en)) begin
            idx       = int'(mem_input_tag[1:0]);
            last_addr = mem_addresses;
            if (mem_wr_en) begin
                if (mem_gm_or_lds) lds_mem[mem_addresses[9:2]] = mem_wr_data;
                else gm_mem[mem_addresses[9:2]] = mem_wr_data;
            end
            check_eq("strobe_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                t = exp_q.pop_front();
                check_eq("mem_rd_en", mem_rd_en, !t.wr);
                check_eq("mem_wr_en", mem_wr_en, t.wr);
                check_eq("mem_addr", mem_addresses, t.addr);
                check_eq("mem_tag", mem_input_tag, t.tag);
                check_eq("mem_space", mem_gm_or_lds, t.lds);
                if (t.wr) check_eq("mem_wr_data", mem_wr_data, t.data);
            end
            if (idx == bad_idx) begin
                ack_q.push_back('{due: cyc + 1, tag: {mem_input_tag[6:2], 2'(idx + 1)}, chk: 1'b1});
                ack_q.push_back('{due: cyc + 4, tag: mem_input_tag, chk: 1'b1});
            end else if (idx != drop_idx) begin
                ack_q.push_back('{due: cyc + 1, tag: mem_input_tag, chk: 1'b1});
            end
        end
    end

    // Reference: expected accesses, gathered data, error flag and cycles to resp_valid.
    task automatic plan_req(input logic wr, input logic lds, input logic [31:0] addr,
                            input logic [2:0] cnt, input logic [DW-1:0] data,
                            input logic [4:0] tag, input int drop, input int bad,
                            output logic [DW-1:0] exp_rd, output logic exp_err,
                            output int exp_lat);
        int          n;
        logic [31:0] a;
        logic [7:0]  w;
        n       = (cnt == 3'd0) ? 1 : ((int'(cnt) > MAX_WORDS) ? MAX_WORDS : int'(cnt));
        exp_err = (int'(cnt) > MAX_WORDS);
        exp_rd  = '0;
        exp_lat = 1;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(4 * i);
            w = a[9:2];
            exp_q.push_back('{wr: wr, lds: lds, addr: a, tag: {tag, 2'(i)},
                              data: data[32*i +: 32]});
            if (wr) begin
                if (lds) shadow_lds[w] = data[32*i +: 32];
                else shadow_gm[w] = data[32*i +: 32];
            end else if (i != drop) begin
                exp_rd[32*i +: 32] = lds ? shadow_lds[w] : shadow_gm[w];
            end
            if (i == drop) begin
                exp_err = 1'b1;
                exp_lat += 1 + TIMEOUT;
            end else if (i == bad) begin
                exp_err = 1'b1;
                exp_lat += 1 + 4;
            end else begin
                exp_lat += 2;
            end
        end
    endtask

    task automatic do_req(input logic wr, input logic lds, input logic [31:0] addr,
                          input logic [2:0] cnt, input logic [DW-1:0] data,
                          input logic [4:0] tag, input int drop, input int bad, input int hold);
        logic [DW-1:0] exp_rd;
        logic          exp_err;
        int            exp_lat;
        int            lat;
        bit            got;
        plan_req(wr, lds, addr, cnt, data, tag, drop, bad, exp_rd, exp_err, exp_lat);
        drop_idx = drop;
        bad_idx  = bad;
        @(negedge clk);
        check_eq("req_ready_idle", req_ready, 1'b1);
        req_wr        = wr;
        req_gm_or_lds = lds;
        req_addr      = addr;
        req_count     = cnt;
        req_wr_data   = data;
        req_tag       = tag;
        req_valid     = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 400) begin
            @(negedge clk);
            lat++;
            got = resp_valid;
        end
        check_eq("resp_arrived", got, 1'b1);
        if (got) begin
            check_eq("latency", lat, exp_lat);
            check_eq("resp_rd_data", resp_rd_data, exp_rd);
            check_eq("resp_tag", resp_tag, tag);
            check_eq("resp_err", resp_err, exp_err);
            check_eq("req_ready_busy", req_ready, 1'b0);
            for (int h = 0; h < hold; h++) begin
                req_valid     = 1'b1;
                req_wr        = 1'($urandom);
                req_addr      = $urandom & 32'hFFFF_FFFC;
                req_count     = 3'($urandom_range(1, 4));
                req_tag       = 5'($urandom);
                @(negedge clk);
                check_eq("hold_valid", resp_valid, 1'b1);
                check_eq("hold_rd_data", resp_rd_data, exp_rd);
                check_eq("hold_tag", resp_tag, tag);
                check_eq("hold_req_ready", req_ready, 1'b0);
            end
            req_valid  = 1'b0;
            resp_ready = 1'b1;
            @(posedge clk);
            #1 resp_ready = 1'b0;
            @(negedge clk);
            check_eq("resp_dropped", resp_valid, 1'b0);
            check_eq("req_ready_after", req_ready, 1'b1);
        end else begin
            rst_n = 1'b0;
            #1;
            exp_q.delete();
            ack_q.delete();
            @(negedge clk);
            rst_n = 1'b1;
        end
        drop_idx = -1;
        bad_idx  = -1;
    endtask

    initial begin
        logic [DW-1:0] er;
        logic          ee;
        int            el;
        logic [31:0]   v;
        bit            seen;

        rst_n          = 1'b1;
        req_valid      = 1'b0;
        req_wr         = 1'b0;
        req_gm_or_lds  = 1'b0;
        req_addr       = '0;
        req_count      = '0;
        req_wr_data    = '0;
        req_tag        = '0;
        resp_ready     = 1'b0;
        mem_ack        = 1'b0;
        mem_output_tag = '0;
        for (int i = 0; i < 256; i++) begin
            v             = $urandom;
            gm_mem[i]     = v;
            shadow_gm[i]  = v;
            v             = $urandom;
            lds_mem[i]    = v;
            shadow_lds[i] = v;
        end
        gm_mem[8'h40] = 32'h1122_3344; shadow_gm[8'h40] = 32'h1122_3344;
        gm_mem[8'h41] = 32'h5566_7788; shadow_gm[8'h41] = 32'h5566_7788;
        gm_mem[8'h42] = 32'h99AA_BBCC; shadow_gm[8'h42] = 32'h99AA_BBCC;
        gm_mem[8'h43] = 32'hDDEE_FF00; shadow_gm[8'h43] = 32'hDDEE_FF00;

        #2 rst_n = 1'b0;
        #3;
        check_eq("rst_req_ready", req_ready, 1'b1);
        check_eq("rst_resp_valid", resp_valid, 1'b0);
        check_eq("rst_strobes", {mem_rd_en, mem_wr_en}, 2'b00);
        check_eq("rst_addr", mem_addresses, 32'h0);
        check_eq("rst_tag", mem_input_tag, 7'h0);
        check_eq("rst_rd_data", resp_rd_data, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Four-word GM read of the preloaded block.
        do_req(1'b0, 1'b0, 32'h100, 3'd4, '0, 5'h0A, -1, -1, 0);
        // LDS write then read-back.
        do_req(1'b1, 1'b1, 32'h20, 3'd2, {64'h0, 32'h1234_5678, 32'hCAFE_BABE}, 5'h03, -1, -1, 0);
        do_req(1'b0, 1'b1, 32'h20, 3'd2, '0, 5'h04, -1, -1, 0);
        // Dropped ack on word 1, then wrong-tag ack on word 1.
        do_req(1'b0, 1'b0, 32'h200, 3'd3, '0, 5'h11, 1, -1, 0);
        do_req(1'b0, 1'b0, 32'h300, 3'd3, '0, 5'h12, -1, 1, 0);
        // Response back-pressure.
        do_req(1'b0, 1'b1, 32'h40, 3'd4, '0, 5'h1F, -1, -1, 5);
        // Count clamping and address wrap.
        do_req(1'b0, 1'b0, 32'h400, 3'd7, '0, 5'h07, -1, -1, 0);
        do_req(1'b1, 1'b0, 32'h80, 3'd0, {96'h0, 32'hA5A5_0F0F}, 5'h08, -1, -1, 0);
        do_req(1'b0, 1'b0, 32'hFFFF_FFF8, 3'd4, '0, 5'h09, -1, -1, 0);

        // Reset while waiting on word 2 of a read.
        plan_req(1'b0, 1'b0, 32'h100, 3'd4, '0, 5'h15, 2, -1, er, ee, el);
        drop_idx = 2;
        @(negedge clk);
        req_wr        = 1'b0;
        req_gm_or_lds = 1'b0;
        req_addr      = 32'h100;
        req_count     = 3'd4;
        req_tag       = 5'h15;
        req_valid     = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            seen = mem_rd_en && (mem_input_tag[1:0] == 2'd2);
        end
        check_eq("reset_reach_wait", seen, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_req_ready", req_ready, 1'b1);
        check_eq("midrst_resp_valid", resp_valid, 1'b0);
        check_eq("midrst_strobes", {mem_rd_en, mem_wr_en}, 2'b00);
        check_eq("midrst_addr", mem_addresses, 32'h0);
        check_eq("midrst_tag", mem_input_tag, 7'h0);
        check_eq("midrst_rd_data", resp_rd_data, '0);
        check_eq("midrst_err", resp_err, 1'b0);
        exp_q.delete();
        ack_q.delete();
        drop_idx = -1;
        @(negedge clk);
        rst_n = 1'b1;
        ack_q.push_back('{due: cyc + 2, tag: {5'h15, 2'd2}, chk: 1'b0});
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_eq("postrst_no_resp", resp_valid, 1'b0);
            check_eq("postrst_ready", req_ready, 1'b1);
        end
        do_req(1'b0, 1'b0, 32'h100, 3'd4, '0, 5'h16, -1, -1, 0);

        for (int r = 0; r < 24; r++) begin
            do_req(1'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC,
                   3'($urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom},
                   5'($urandom), -1, -1, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
